dmem_pipe: RTL

//  Parametrised data memory for the MEMORY stage; successor to the single-cycle data memory.

---
 rtl/dmem_pipe.sv | 103 ++++++++++
 1 files changed

// File: rtl/dmem_pipe.sv
// dmem_pipe: byte-addressed word memory behind a valid/ready port with fixed access latency.
module dmem_pipe #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int LATENCY     = 2,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              err_sticky,
  output logic              busy
);
  localparam int OB = $clog2(DATA_W / 8);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic resp_error_q, resp_error_d, err_sticky_q, err_sticky_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] req_word;
  logic accept, req_err, commit, live, c_wr, c_err;
  logic [IW-1:0] c_idx;
  logic [DATA_W-1:0] c_wdata;
  assign req_word = req_addr >> OB;
  assign req_err = (ALIGN_CHECK != 0 && (req_addr & ADDR_W'(DATA_W / 8 - 1)) != '0)
                   || req_word >= ADDR_W'(DEPTH);
  assign resp_valid = state_q == RESP;
  assign busy = state_q == WAIT;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign err_sticky = err_sticky_q;
  always_comb begin
    req_ready = state_q == IDLE || state_q == RESP;
    accept = req_valid && req_ready;
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    err_d = err_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    if (accept) begin
      state_d = LATENCY == 1 ? RESP : WAIT;
      cnt_d = CNT_INIT;
      wr_d = req_write;
      err_d = req_err;
      idx_d = req_word[IW-1:0];
      wdata_d = req_wdata;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    // Outside WAIT a commit can only be a latency-1 accept, so it uses the live request.
    commit = state_d == RESP;
    live = state_q != WAIT;
    c_wr = live ? req_write : wr_q;
    c_err = live ? req_err : err_q;
    c_idx = live ? req_word[IW-1:0] : idx_q;
    c_wdata = live ? req_wdata : wdata_q;
    resp_rdata_d = commit ? (c_err ? '0 : c_wr ? c_wdata : mem[c_idx]) : resp_rdata_q;
    resp_error_d = commit ? c_err : resp_error_q;
    err_sticky_d = err_sticky_q | (commit & c_err);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      err_q <= err_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      err_sticky_q <= err_sticky_d;
      if (commit && c_wr && !c_err) mem[c_idx] <= c_wdata;
    end
  end
endmodule
